// File: rtl/wb_commit_buffer.sv
// wb_commit_buffer: MEM->WB commit stage. A 2-entry skid buffer holds N-lane
// commit bundles under a valid/ready handshake. Lanes behind an excepting
// lane are squashed on entry. The head entry drives the ctrl view and the
// forwarding view. A retired-instruction counter advances on every pop.
module wb_commit_buffer #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 14,
  parameter int EXC_W  = 7,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_valid,
  input  logic [LANES-1:0]          in_reg_we,
  input  logic [LANES*REG_AW-1:0]   in_reg_addr,
  input  logic [LANES*DATA_W-1:0]   in_reg_data,
  input  logic [LANES-1:0]          in_csr_we,
  input  logic [LANES*CSR_AW-1:0]   in_csr_addr,
  input  logic [LANES*DATA_W-1:0]   in_csr_data,
  input  logic [LANES*DATA_W-1:0]   in_pc,
  input  logic [LANES-1:0]          in_exc,
  input  logic [LANES*EXC_W-1:0]    in_ecode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_valid,
  output logic [LANES-1:0]          out_reg_we,
  output logic [LANES*REG_AW-1:0]   out_reg_addr,
  output logic [LANES*DATA_W-1:0]   out_reg_data,
  output logic [LANES-1:0]          out_csr_we,
  output logic [LANES*CSR_AW-1:0]   out_csr_addr,
  output logic [LANES*DATA_W-1:0]   out_csr_data,
  output logic [LANES*DATA_W-1:0]   out_pc,
  output logic [LANES-1:0]          out_exc,
  output logic [LANES*EXC_W-1:0]    out_ecode,
  output logic [LANES-1:0]          fwd_we,
  output logic [LANES*REG_AW-1:0]   fwd_addr,
  output logic [LANES*DATA_W-1:0]   fwd_data,
  output logic [CNT_W-1:0]          retired_cnt
);

  typedef struct packed {
    logic [LANES-1:0]        lane_valid;
    logic [LANES-1:0]        reg_we;
    logic [LANES*REG_AW-1:0] reg_addr;
    logic [LANES*DATA_W-1:0] reg_data;
    logic [LANES-1:0]        csr_we;
    logic [LANES*CSR_AW-1:0] csr_addr;
    logic [LANES*DATA_W-1:0] csr_data;
    logic [LANES*DATA_W-1:0] pc;
    logic [LANES-1:0]        exc;
    logic [LANES*EXC_W-1:0]  ecode;
  } bundle_t;

  // Number of lanes that retire: valid and not excepting.
  function automatic logic [CNT_W-1:0] retire_count(input logic [LANES-1:0] lv,
                                                    input logic [LANES-1:0] ex);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + CNT_W'(lv[i] & ~ex[i]);
    end
    return c;
  endfunction

  bundle_t          head_q, head_d, skid_q, skid_d, sq_s;
  logic             head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_s, pop_s;

  assign in_ready = ~skid_valid_q;
  assign accept_s = in_valid & ~skid_valid_q & ~flush;
  assign pop_s    = head_valid_q & out_ready;

  // Ingress squash: kill writes at/after the first excepting lane and r0 writes.
  always_comb begin
    logic seen;
    seen = 1'b0;
    sq_s = '{lane_valid: in_lane_valid, reg_we: in_reg_we, reg_addr: in_reg_addr,
             reg_data: in_reg_data, csr_we: in_csr_we, csr_addr: in_csr_addr,
             csr_data: in_csr_data, pc: in_pc, exc: in_exc, ecode: in_ecode};
    for (int i = 0; i < LANES; i++) begin
      if (!in_lane_valid[i]) begin
        sq_s.reg_we[i] = 1'b0;
        sq_s.csr_we[i] = 1'b0;
        sq_s.exc[i]    = 1'b0;
      end else if (seen) begin
        sq_s.lane_valid[i] = 1'b0;
        sq_s.reg_we[i]     = 1'b0;
        sq_s.csr_we[i]     = 1'b0;
      end else if (in_exc[i]) begin
        sq_s.reg_we[i] = 1'b0;
        sq_s.csr_we[i] = 1'b0;
        seen           = 1'b1;
      end else begin
        sq_s.lane_valid[i] = 1'b1;
      end
      sq_s.reg_we[i] = sq_s.reg_we[i] & (|in_reg_addr[i*REG_AW +: REG_AW]);
    end
  end

  // Next-state for both entries and the retire counter; head payload is kept
  // at zero whenever head is empty so the outputs need no gating.
  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (pop_s) begin
      cnt_d = cnt_q + retire_count(head_q.lane_valid, head_q.exc);
    end else begin
      cnt_d = cnt_q;
    end
    if (flush) begin
      head_d       = '0;
      head_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || (pop_s && !skid_valid_q)) begin
      head_d       = accept_s ? sq_s : '0;
      head_valid_d = accept_s;
    end else if (pop_s) begin
      head_d       = skid_q;
      head_valid_d = 1'b1;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (accept_s) begin
      skid_d       = sq_s;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid      = head_valid_q;
  assign out_lane_valid = head_q.lane_valid;
  assign out_reg_we     = head_q.reg_we;
  assign out_reg_addr   = head_q.reg_addr;
  assign out_reg_data   = head_q.reg_data;
  assign out_csr_we     = head_q.csr_we;
  assign out_csr_addr   = head_q.csr_addr;
  assign out_csr_data   = head_q.csr_data;
  assign out_pc         = head_q.pc;
  assign out_exc        = head_q.exc;
  assign out_ecode      = head_q.ecode;
  assign fwd_we         = {LANES{head_valid_q}} & head_q.reg_we;
  assign fwd_addr       = head_q.reg_addr;
  assign fwd_data       = head_q.reg_data;
  assign retired_cnt    = cnt_q;

endmodule
